// File: rtl/cdc_handshake_tx_if.sv
// Bundle of the upstream valid/ready port and the req/ack/data crossing for cdc_handshake_tx.
// master is the transmitter's view; slave is the upstream/destination side.
interface cdc_handshake_tx_if #(
    parameter int DATA_W = 32
);
    logic              valid_i;
    logic [DATA_W-1:0] data_i;
    logic              ready_o;
    logic              req_o;
    logic [DATA_W-1:0] data_o;
    logic              ack_i;
    logic              done_o;
    logic              timeout_o;

    modport master (
        input  valid_i, data_i, ack_i,
        output ready_o, req_o, data_o, done_o, timeout_o
    );

    modport slave (
        output valid_i, data_i, ack_i,
        input  ready_o, req_o, data_o, done_o, timeout_o
    );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source-side transmitter of a 4-phase req/ack CDC handshake: captures one word, holds it
// on data_o while req is raised, and closes the protocol once the synchronized ack falls.
module cdc_handshake_tx #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cdc_handshake_tx_if.master     bus
);
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit TO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   ack_s;
    logic                   accept_s;
    logic                   req_r, req_s;
    logic [DATA_W-1:0]      data_r, data_s;
    logic                   done_r, done_s;
    logic                   timeout_r, timeout_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;

    // ack_i is asynchronous to clk; only the last stage of this chain is ever used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], bus.ack_i};
        end
    end

    assign ack_s    = sync_r[SYNC_STAGES-1];
    assign accept_s = bus.valid_i && bus.ready_o;

    // Next-state and next-output logic for the IDLE -> REQ -> REL handshake.
    always_comb begin
        state_s   = state_r;
        req_s     = req_r;
        data_s    = data_r;
        done_s    = 1'b0;
        timeout_s = timeout_r;
        cnt_s     = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    data_s    = bus.data_i;
                    req_s     = 1'b1;
                    state_s   = ST_REQ;
                    cnt_s     = {CNT_W{1'b0}};
                    timeout_s = 1'b0;
                end else begin
                    req_s = 1'b0;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    req_s   = 1'b0;
                    state_s = ST_REL;
                end else if (TO_EN && (cnt_r == CNT_LAST)) begin
                    // Abort: still pass through REL so the receiver sees req fall.
                    req_s     = 1'b0;
                    timeout_s = 1'b1;
                    state_s   = ST_REL;
                end else begin
                    req_s = 1'b1;
                    if (cnt_r != CNT_MAX) begin
                        cnt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
            end
            ST_REL: begin
                if (!ack_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    req_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_IDLE;
                req_s   = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // Handshake state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            req_r     <= 1'b0;
            data_r    <= {DATA_W{1'b0}};
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_s;
            req_r     <= req_s;
            data_r    <= data_s;
            done_r    <= done_s;
            timeout_r <= timeout_s;
            cnt_r     <= cnt_s;
        end
    end

    // A stale-high synchronized ack keeps new transfers out until the receiver has released.
    assign bus.ready_o   = (state_r == ST_IDLE) && !ack_s;
    assign bus.req_o     = req_r;
    assign bus.data_o    = data_r;
    assign bus.done_o    = done_r;
    assign bus.timeout_o = timeout_r;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: table of transfers checked through a
// done_o-driven scoreboard, plus hand sequences for stale ack, reset and ignored inputs.
module tb_cdc_handshake_tx;
    localparam int DW = 32;
    localparam int SS = 2;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cdc_handshake_tx_if #(.DATA_W(DW)) bus ();

    cdc_handshake_tx #(.DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int chk  = 0;
    int fail = 0;
    int cyc  = 0;

    // 0: ack tied low, 1: ack = req instantly, 2: ack follows req 3 cycles late, 3: ack forced high
    int   ack_mode = 0;
    logic ack_dly  = 1'b0;
    int   dcnt     = 0;
    assign bus.ack_i = (ack_mode == 1) ? bus.req_o : (ack_mode == 3) ? 1'b1 : ack_dly;

    always @(posedge clk) cyc <= cyc + 1;

    // Delayed responder
    always @(posedge clk) begin
        if (ack_mode != 2) begin
            ack_dly <= 1'b0;
            dcnt    <= 0;
        end else if (bus.req_o != ack_dly) begin
            if (dcnt == 2) begin
                ack_dly <= bus.req_o;
                dcnt    <= 0;
            end else begin
                dcnt <= dcnt + 1;
            end
        end else begin
            dcnt <= 0;
        end
    end

    typedef struct {
        logic [31:0] data;
        int          exp_lat;
        logic        exp_to;
        int          acc_cyc;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [31:0] data;
        int          mode;
        int          exp_lat;
        logic        exp_to;
        int          exp_gap;
    } vec_t;
    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            fail++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: each done_o pulse closes the oldest outstanding transfer
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.req_o && sb_q.size() > 0) check("data_hold", bus.data_o, sb_q[0].data);
            if (bus.done_o) begin
                if (sb_q.size() == 0) begin
                    check("spurious_done", {31'd0, bus.done_o}, 32'd0);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    check("latency", cyc - e.acc_cyc, e.exp_lat);
                    check("done_data", bus.data_o, e.data);
                    check("done_timeout", {31'd0, bus.timeout_o}, {31'd0, e.exp_to});
                end
            end
        end
    end

    // Called at a negedge with valid_i intended high; waits for ready, then accepts one word.
    task automatic send(input logic [31:0] d, input int mode, input int lat, input logic to,
                        output int acc);
        int i;
        acc = -1;
        bus.valid_i = 1'b1;
        for (i = 0; i < 200 && !bus.ready_o; i++) @(negedge clk);
        if (!bus.ready_o) begin
            check("ready_wait", {31'd0, bus.ready_o}, 32'd1);
            return;
        end
        ack_mode   = mode;
        bus.data_i = d;
        @(posedge clk);
        #1;
        acc = cyc;
        sb_q.push_back('{data: d, exp_lat: lat, exp_to: to, acc_cyc: acc});
        @(negedge clk);
        check("acc_req", {31'd0, bus.req_o}, 32'd1);
        check("acc_data", bus.data_o, d);
        check("acc_timeout", {31'd0, bus.timeout_o}, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb_q.size() > 0; i++) @(negedge clk);
        check("drain", sb_q.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, prev_acc;

        vt[0] = '{32'hDEADBEEF, 2, 12, 1'b0, 0};
        vt[1] = '{32'h00000001, 1, 6,  1'b0, 13};
        vt[2] = '{32'h00000002, 1, 6,  1'b0, 7};
        vt[3] = '{32'h00000003, 1, 6,  1'b0, 7};
        vt[4] = '{32'h00000005, 0, 17, 1'b1, 7};
        vt[5] = '{32'hA5A5A5A5, 1, 6,  1'b0, 18};

        bus.valid_i = 1'b0;
        bus.data_i  = 32'h0;

        // Reset state
        #12;
        check("rst_req", {31'd0, bus.req_o}, 32'd0);
        check("rst_data", bus.data_o, 32'd0);
        check("rst_done", {31'd0, bus.done_o}, 32'd0);
        check("rst_timeout", {31'd0, bus.timeout_o}, 32'd0);
        check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: valid_i held high across entries so successive accepts are back-to-back
        prev_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(vt[i].data, vt[i].mode, vt[i].exp_lat, vt[i].exp_to, acc);
            if (vt[i].exp_gap != 0) check("accept_gap", acc - prev_acc, vt[i].exp_gap);
            prev_acc = acc;
        end
        bus.valid_i = 1'b0;
        drain();

        // Ignored inputs during REQ/REL
        send(32'hCAFEF00D, 2, 12, 1'b0, acc);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("ign_data", bus.data_o, 32'hCAFEF00D);
            if (bus.ready_o) begin
                bus.valid_i = 1'b0;
                break;
            end
            bus.data_i  = ~bus.data_i;
            bus.valid_i = ~bus.valid_i;
        end
        bus.valid_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("ign_no_accept", {31'd0, bus.req_o}, 32'd0);
        end
        drain();

        // Stale ack held through reset
        ack_mode = 3;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (SS) @(negedge clk);
        bus.valid_i = 1'b1;
        bus.data_i  = 32'h00000077;
        repeat (4) begin
            @(negedge clk);
            check("stale_ready", {31'd0, bus.ready_o}, 32'd0);
            check("stale_req", {31'd0, bus.req_o}, 32'd0);
        end
        ack_mode = 1;
        @(negedge clk);
        check("stale_ready_1", {31'd0, bus.ready_o}, 32'd0);
        @(negedge clk);
        check("stale_ready_2", {31'd0, bus.ready_o}, 32'd1);
        @(posedge clk);
        #1;
        sb_q.push_back('{data: 32'h00000077, exp_lat: 6, exp_to: 1'b0, acc_cyc: cyc});
        @(negedge clk);
        bus.valid_i = 1'b0;
        check("stale_accept", {31'd0, bus.req_o}, 32'd1);
        drain();

        // Asynchronous reset in the middle of REQ
        send(32'h12345678, 0, 17, 1'b1, acc);
        bus.valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", {31'd0, bus.req_o}, 32'd0);
        check("arst_data", bus.data_o, 32'd0);
        check("arst_timeout", {31'd0, bus.timeout_o}, 32'd0);
        check("arst_done", {31'd0, bus.done_o}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_ready", {31'd0, bus.ready_o}, 32'd1);
        check("arst_req_rel", {31'd0, bus.req_o}, 32'd0);
        send(32'h0BADF00D, 1, 6, 1'b0, acc);
        bus.valid_i = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", chk, fail);
        $finish;
    end
endmodule
